// File: rtl/iteration_sequencer.sv
// ---------------------------------------------------------------------------
// iteration_sequencer : HPS command decoder and iterative SDRAM pass engine
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module iteration_sequencer #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 16,
   parameter int ITER_W = 16
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic [31:0]       control_data,
   input  logic              control_set,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_read,
   output logic              avm_write,
   output logic [DATA_W-1:0] avm_writedata,
   input  logic [DATA_W-1:0] avm_readdata,
   input  logic              avm_readdatavalid,
   input  logic              avm_waitrequest,
   output logic [DATA_W-1:0] src_data,
   output logic              src_valid,
   input  logic              src_ready,
   input  logic [DATA_W-1:0] snk_data,
   input  logic              snk_valid,
   output logic              snk_ready,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ITER_W-1:0] iter_count
);

   localparam logic [3:0] OP_SET_SRC  = 4'd1;
   localparam logic [3:0] OP_SET_DST  = 4'd2;
   localparam logic [3:0] OP_SET_LEN  = 4'd3;
   localparam logic [3:0] OP_SET_ITER = 4'd4;
   localparam logic [3:0] OP_START    = 4'd5;
   localparam logic [3:0] OP_ABORT    = 4'd6;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RD    = 3'd1,
      S_RWAIT = 3'd2,
      S_PUSH  = 3'd3,
      S_PULL  = 3'd4,
      S_WR    = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic              set_q, set_d;
   logic [ADDR_W-1:0] src_base_q, src_base_d, dst_base_q, dst_base_d;
   logic [ADDR_W-1:0] cur_src_q, cur_src_d, cur_dst_q, cur_dst_d;
   logic [LEN_W-1:0]  len_q, len_d, idx_q, idx_d;
   logic [ITER_W-1:0] iter_q, iter_d, iter_count_q, iter_count_d;
   logic              busy_q, busy_d, done_q, done_d, error_q, error_d;
   logic              abort_pend_q, abort_pend_d;
   logic              avm_read_q, avm_read_d, avm_write_q, avm_write_d;
   logic [ADDR_W-1:0] avm_address_q, avm_address_d;
   logic [DATA_W-1:0] avm_writedata_q, avm_writedata_d, src_data_q, src_data_d;
   logic              src_valid_q, src_valid_d, snk_ready_q, snk_ready_d;

   logic              cmd_fire, start_cmd, abort_cmd, last_iter;
   logic [3:0]        opcode;
   logic [27:0]       payload;
   logic [ITER_W-1:0] iter_next;

   function automatic logic [ADDR_W-1:0] elem_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [LEN_W-1:0]  idx);
      elem_addr = base + (ADDR_W'(idx) << 2);
   endfunction

   assign opcode    = control_data[31:28];
   assign payload   = control_data[27:0];
   assign cmd_fire  = control_set & ~set_q;
   assign start_cmd = cmd_fire && (opcode == OP_START) && !busy_q;
   assign abort_cmd = cmd_fire && (opcode == OP_ABORT) && busy_q;
   assign iter_next = iter_count_q + ITER_W'(1);

   always_comb begin
      state_d         = state_q;
      set_d           = control_set;
      src_base_d      = src_base_q;
      dst_base_d      = dst_base_q;
      len_d           = len_q;
      iter_d          = iter_q;
      cur_src_d       = cur_src_q;
      cur_dst_d       = cur_dst_q;
      idx_d           = idx_q;
      iter_count_d    = iter_count_q;
      busy_d          = busy_q;
      done_d          = done_q;
      error_d         = error_q;
      abort_pend_d    = abort_pend_q;
      avm_read_d      = avm_read_q;
      avm_write_d     = avm_write_q;
      avm_address_d   = avm_address_q;
      avm_writedata_d = avm_writedata_q;
      src_data_d      = src_data_q;
      src_valid_d     = src_valid_q;
      snk_ready_d     = snk_ready_q;
      last_iter       = 1'b0;

      if (cmd_fire && !busy_q) begin
         unique case (opcode)
            OP_SET_SRC:  src_base_d = ADDR_W'({payload, 2'b00});
            OP_SET_DST:  dst_base_d = ADDR_W'({payload, 2'b00});
            OP_SET_LEN:  len_d      = payload[LEN_W-1:0];
            OP_SET_ITER: iter_d     = payload[ITER_W-1:0];
            default: ;
         endcase
      end
      if (abort_cmd) abort_pend_d = 1'b1;

      unique case (state_q)
         S_IDLE: begin
            if (start_cmd) begin
               if (len_q == '0 || iter_q == '0) begin
                  error_d = 1'b1;
               end else begin
                  busy_d        = 1'b1;
                  done_d        = 1'b0;
                  error_d       = 1'b0;
                  abort_pend_d  = 1'b0;
                  iter_count_d  = '0;
                  idx_d         = '0;
                  cur_src_d     = src_base_q;
                  cur_dst_d     = dst_base_q;
                  avm_read_d    = 1'b1;
                  avm_address_d = src_base_q;
                  state_d       = S_RD;
               end
            end
         end
         S_RD: begin
            if (!avm_waitrequest) begin
               avm_read_d = 1'b0;
               state_d    = S_RWAIT;
            end
         end
         S_RWAIT: begin
            if (avm_readdatavalid) begin
               src_data_d  = avm_readdata;
               src_valid_d = 1'b1;
               state_d     = S_PUSH;
            end
         end
         S_PUSH: begin
            if (src_ready) begin
               src_valid_d = 1'b0;
               snk_ready_d = 1'b1;
               state_d     = S_PULL;
            end
         end
         S_PULL: begin
            if (snk_valid) begin
               snk_ready_d     = 1'b0;
               avm_writedata_d = snk_data;
               avm_write_d     = 1'b1;
               avm_address_d   = elem_addr(cur_dst_q, idx_q);
               state_d         = S_WR;
            end
         end
         S_WR: begin
            if (!avm_waitrequest) begin
               avm_write_d = 1'b0;
               if (idx_q != len_q - LEN_W'(1)) begin
                  idx_d = idx_q + LEN_W'(1);
               end else begin
                  // End of a pass: the buffer just written becomes the next source.
                  iter_count_d = iter_next;
                  cur_src_d    = cur_dst_q;
                  cur_dst_d    = cur_src_q;
                  idx_d        = '0;
                  last_iter    = (iter_next == iter_q);
               end
               if (abort_pend_q || abort_cmd) begin
                  abort_pend_d = 1'b0;
                  busy_d       = 1'b0;
                  state_d      = S_IDLE;
               end else if (last_iter) begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  avm_read_d    = 1'b1;
                  avm_address_d = elem_addr(cur_src_d, idx_d);
                  state_d       = S_RD;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q         <= S_IDLE;
         set_q           <= 1'b0;
         src_base_q      <= '0;
         dst_base_q      <= '0;
         len_q           <= '0;
         iter_q          <= '0;
         cur_src_q       <= '0;
         cur_dst_q       <= '0;
         idx_q           <= '0;
         iter_count_q    <= '0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         error_q         <= 1'b0;
         abort_pend_q    <= 1'b0;
         avm_read_q      <= 1'b0;
         avm_write_q     <= 1'b0;
         avm_address_q   <= '0;
         avm_writedata_q <= '0;
         src_data_q      <= '0;
         src_valid_q     <= 1'b0;
         snk_ready_q     <= 1'b0;
      end else begin
         state_q         <= state_d;
         set_q           <= set_d;
         src_base_q      <= src_base_d;
         dst_base_q      <= dst_base_d;
         len_q           <= len_d;
         iter_q          <= iter_d;
         cur_src_q       <= cur_src_d;
         cur_dst_q       <= cur_dst_d;
         idx_q           <= idx_d;
         iter_count_q    <= iter_count_d;
         busy_q          <= busy_d;
         done_q          <= done_d;
         error_q         <= error_d;
         abort_pend_q    <= abort_pend_d;
         avm_read_q      <= avm_read_d;
         avm_write_q     <= avm_write_d;
         avm_address_q   <= avm_address_d;
         avm_writedata_q <= avm_writedata_d;
         src_data_q      <= src_data_d;
         src_valid_q     <= src_valid_d;
         snk_ready_q     <= snk_ready_d;
      end
   end

   assign avm_address   = avm_address_q;
   assign avm_read      = avm_read_q;
   assign avm_write     = avm_write_q;
   assign avm_writedata = avm_writedata_q;
   assign src_data      = src_data_q;
   assign src_valid     = src_valid_q;
   assign snk_ready     = snk_ready_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign error         = error_q;
   assign iter_count    = iter_count_q;

endmodule

`default_nettype wire

// File: tb/tb_iteration_sequencer.sv
// ---------------------------------------------------------------------------
// tb_iteration_sequencer : randomized bench with Avalon slave, echo core and pass model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_iteration_sequencer;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int LW = 16;
   localparam int IW = 16;

   localparam logic [3:0] OP_SRC = 4'd1, OP_DST = 4'd2, OP_LEN = 4'd3;
   localparam logic [3:0] OP_ITER = 4'd4, OP_START = 4'd5, OP_ABORT = 4'd6;

   logic          clk_clk = 1'b0;
   logic          reset_reset_n;
   logic [31:0]   control_data;
   logic          control_set;
   logic [AW-1:0] avm_address;
   logic          avm_read, avm_write;
   logic [DW-1:0] avm_writedata, avm_readdata;
   logic          avm_readdatavalid, avm_waitrequest;
   logic [DW-1:0] src_data, snk_data;
   logic          src_valid, src_ready, snk_valid, snk_ready;
   logic          busy, done, error;
   logic [IW-1:0] iter_count;

   always #5 clk_clk = ~clk_clk;

   iteration_sequencer #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .ITER_W(IW)) dut (
      .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
      .control_data(control_data), .control_set(control_set),
      .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
      .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
      .avm_readdatavalid(avm_readdatavalid), .avm_waitrequest(avm_waitrequest),
      .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
      .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
      .busy(busy), .done(done), .error(error), .iter_count(iter_count)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Word-addressed SDRAM image (addresses kept below 0x4000)
   logic [31:0] mem [0:4095];
   logic [31:0] mdl [0:4095];
   logic [31:0] rd_log[$], wr_a_log[$], wr_d_log[$];
   logic [31:0] exp_rd[$], exp_wa[$], exp_wd[$];
   logic [31:0] core_q[$];
   bit          stall = 1'b0;
   int          rd_lat;
   logic [31:0] rd_data;
   bit          prev_stalled;
   logic [31:0] prev_addr, prev_wdata;
   logic        prev_rd, prev_wr;

   // Slave and compute core: values set here are what the next posedge sees
   always @(negedge clk_clk) begin
      if (!reset_reset_n) begin
         rd_lat = 0; prev_stalled = 1'b0; core_q.delete();
         avm_readdatavalid = 1'b0; avm_waitrequest = 1'b0;
         snk_valid = 1'b0; src_ready = 1'b0;
      end else begin
         if (prev_stalled) begin
            check("addr_stable", avm_address, prev_addr);
            check("cmd_stable", {avm_read, avm_write}, {prev_rd, prev_wr});
            if (prev_wr) check("wdata_stable", avm_writedata, prev_wdata);
         end
         check("rd_wr_excl", avm_read & avm_write, 0);
         avm_readdatavalid = 1'b0;
         avm_readdata      = $urandom;
         if (rd_lat > 0) begin
            rd_lat--;
            if (rd_lat == 0) begin
               avm_readdatavalid = 1'b1;
               avm_readdata      = rd_data;
            end
         end
         avm_waitrequest = stall ? ($urandom_range(0, 2) == 0) : 1'b0;
         if (avm_read && !avm_waitrequest) begin
            check("one_outstanding", rd_lat, 0);
            rd_log.push_back(avm_address);
            rd_data = mem[avm_address[13:2]];
            rd_lat  = stall ? $urandom_range(1, 3) : 1;
         end
         if (avm_write && !avm_waitrequest) begin
            mem[avm_address[13:2]] = avm_writedata;
            wr_a_log.push_back(avm_address);
            wr_d_log.push_back(avm_writedata);
         end
         prev_stalled = (avm_read || avm_write) && avm_waitrequest;
         prev_addr = avm_address; prev_wdata = avm_writedata;
         prev_rd = avm_read; prev_wr = avm_write;

         snk_valid = (core_q.size() > 0) && (!stall || $urandom_range(0, 1) == 1);
         snk_data  = (core_q.size() > 0) ? core_q[0] : $urandom;
         if (snk_valid && snk_ready) void'(core_q.pop_front());
         src_ready = !stall || ($urandom_range(0, 1) == 1);
         if (src_valid && src_ready) core_q.push_back(src_data + 32'd1);
      end
   end

   // Reference: whole passes over the buffers, swapping roles after each pass
   task automatic model_run(input logic [31:0] s, input logic [31:0] d, input int len, input int iter);
      logic [31:0] a, w, t;
      mdl = mem;
      exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
      for (int it = 0; it < iter; it++) begin
         for (int i = 0; i < len; i++) begin
            a = s + 32'(4 * i);
            w = d + 32'(4 * i);
            exp_rd.push_back(a);
            mdl[w[13:2]] = mdl[a[13:2]] + 32'd1;
            exp_wa.push_back(w);
            exp_wd.push_back(mdl[w[13:2]]);
         end
         t = s; s = d; d = t;
      end
   endtask

   task automatic clear_logs();
      rd_log.delete(); wr_a_log.delete(); wr_d_log.delete();
   endtask

   task automatic compare_logs(input string tag);
      check({tag, "_nrd"}, rd_log.size(), exp_rd.size());
      check({tag, "_nwr"}, wr_a_log.size(), exp_wa.size());
      for (int i = 0; i < rd_log.size() && i < exp_rd.size(); i++)
         check({tag, "_rd_addr"}, rd_log[i], exp_rd[i]);
      for (int i = 0; i < wr_a_log.size() && i < exp_wa.size(); i++) begin
         check({tag, "_wr_addr"}, wr_a_log[i], exp_wa[i]);
         check({tag, "_wr_data"}, wr_d_log[i], exp_wd[i]);
      end
   endtask

   task automatic send_cmd(input logic [3:0] op, input logic [27:0] p, input int hold = 1);
      @(negedge clk_clk);
      control_data = {op, p};
      control_set  = 1'b1;
      repeat (hold) @(negedge clk_clk);
      control_set = 1'b0;
      @(negedge clk_clk);
   endtask

   task automatic wait_idle(input string tag);
      int cyc = 0;
      while (busy && cyc < 20000) begin
         @(negedge clk_clk);
         cyc++;
      end
      check({tag, "_timeout"}, busy, 0);
      repeat (3) @(negedge clk_clk);
   endtask

   task automatic configure(input logic [27:0] sp, input logic [27:0] dp, input int len, input int iter);
      send_cmd(OP_SRC, sp);
      send_cmd(OP_DST, dp);
      send_cmd(OP_LEN, 28'(len));
      send_cmd(OP_ITER, 28'(iter));
   endtask

   task automatic run_cfg(input string tag, input logic [27:0] sp, input logic [27:0] dp,
                          input int len, input int iter, input bit stl);
      stall = stl;
      configure(sp, dp, len, iter);
      model_run({sp[25:0], 2'b00} + 32'd0, {dp[25:0], 2'b00} + 32'd0, len, iter);
      clear_logs();
      send_cmd(OP_START, 28'd0);
      wait_idle(tag);
      check({tag, "_done"}, done, 1);
      check({tag, "_error"}, error, 0);
      check({tag, "_iters"}, iter_count, iter);
      compare_logs(tag);
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 32'hA000_0000 + 32'(i * 37);
      reset_reset_n = 1'b0;
      control_data = '0; control_set = 1'b0;
      avm_readdata = '0; snk_data = '0;
      repeat (4) @(negedge clk_clk);
      check("rst_outs", {avm_read, avm_write, src_valid, snk_ready, busy, done, error},
            7'b0);
      check("rst_addr", avm_address, 0);
      check("rst_iter", iter_count, 0);
      reset_reset_n = 1'b1;
      repeat (2) @(negedge clk_clk);

      run_cfg("t1", 28'h100, 28'h200, 4, 1, 1'b0);
      check("t1_first_rd", rd_log.size() > 0 ? rd_log[0] : 32'hX, 32'h400);
      check("t1_last_wr", wr_a_log.size() > 3 ? wr_a_log[3] : 32'hX, 32'h80C);

      run_cfg("t3", 28'h100, 28'h200, 4, 3, 1'b0);
      check("t3_iter2_rd", rd_log.size() > 4 ? rd_log[4] : 32'hX, 32'h800);
      check("t3_iter2_wr", wr_a_log.size() > 4 ? wr_a_log[4] : 32'hX, 32'h400);

      // START with LEN=0 is rejected
      send_cmd(OP_LEN, 28'd0);
      clear_logs();
      send_cmd(OP_START, 28'd0);
      repeat (10) @(negedge clk_clk);
      check("len0_error", error, 1);
      check("len0_busy", busy, 0);
      check("len0_nreq", rd_log.size() + wr_a_log.size(), 0);

      for (int k = 0; k < 6; k++) begin
         logic [27:0] sp, dp;
         int len, iter;
         sp   = 28'($urandom_range(0, 1000));
         dp   = sp + 28'd1024 + 28'($urandom_range(0, 1000));
         len  = $urandom_range(1, 6);
         iter = $urandom_range(1, 3);
         run_cfg("rnd_nostall", sp, dp, len, iter, 1'b0);
         run_cfg("rnd_stall", sp, dp, len, iter, 1'b1);
      end

      // ABORT while element 2 of 8 is being pushed
      stall = 1'b0;
      configure(28'h300, 28'h900, 8, 1);
      model_run(32'hC00, 32'h2400, 8, 1);
      clear_logs();
      send_cmd(OP_START, 28'd0);
      begin
         int cyc = 0;
         while (!(rd_log.size() == 3 && src_valid) && cyc < 2000) begin
            @(negedge clk_clk);
            cyc++;
         end
         check("abort_reach_push", cyc < 2000, 1);
      end
      send_cmd(OP_ABORT, 28'd0);
      wait_idle("abort");
      check("abort_done", done, 0);
      check("abort_nwr", wr_a_log.size(), 3);
      for (int i = 0; i < 3 && i < wr_a_log.size(); i++) begin
         check("abort_wr_addr", wr_a_log[i], exp_wa[i]);
         check("abort_wr_data", wr_d_log[i], exp_wd[i]);
      end
      repeat (20) @(negedge clk_clk);
      check("abort_nrd", rd_log.size(), 3);

      // Level-held strobe decodes once
      configure(28'h40, 28'h600, 1, 1);
      clear_logs();
      send_cmd(OP_START, 28'd0, 10);
      wait_idle("hold");
      check("hold_nrd", rd_log.size(), 1);
      check("hold_nwr", wr_a_log.size(), 1);
      check("hold_done", done, 1);

      // SET_LEN while busy leaves the run length intact
      configure(28'h80, 28'h700, 4, 2);
      model_run(32'h200, 32'h1C00, 4, 2);
      clear_logs();
      send_cmd(OP_START, 28'd0);
      check("busy_after_start", busy, 1);
      send_cmd(OP_LEN, 28'd2);
      wait_idle("setbusy");
      compare_logs("setbusy");

      // Asynchronous reset mid-run
      send_cmd(OP_START, 28'd0);
      repeat (7) @(negedge clk_clk);
      #2 reset_reset_n = 1'b0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_req", {avm_read, avm_write, src_valid, snk_ready}, 4'b0);
      check("arst_iter", iter_count, 0);
      @(negedge clk_clk);
      reset_reset_n = 1'b1;
      repeat (2) @(negedge clk_clk);
      send_cmd(OP_START, 28'd0);
      repeat (3) @(negedge clk_clk);
      check("arst_len_cleared", error, 1);
      check("arst_no_run", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
